vector_loader: RTL and testbench
================================

Name: vector_loader

Overview:
- Upstream feeder for the vector core's `we`/`wdata` load port.
- Accepts a stream of N-bit scalar words over a valid/ready handshake and packs WIDTH_VECTOR consecutive words into one vector, lane 0 first.
- Completed vectors are buffered in a small FIFO and presented to the core one per cycle under the core's ready.
- A per-lane mask marks which lanes hold real data when a vector is closed early.

Parameters:
WIDTH_VECTOR, 8, lanes per vector; must be a power of 2.
N, 32, bits per lane word.
DEPTH, 2, vector FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  input  1  single clock; all logic is posedge.
rstn  input  1  asynchronous active-low reset.
s_valid  input  1  scalar word valid.
s_ready  output  1  loader can accept a scalar word.
s_data  input  N  scalar word.
s_last  input  1  closes the current vector with this beat; qualified by s_valid.
m_ready  input  1  core can take a vector this cycle.
we  output  1  vector transfer strobe to the core.
wdata  output  WIDTH_VECTOR x N (packed [WIDTH_VECTOR-1:0][N-1:0])  head vector.
wmask  output  WIDTH_VECTOR  lanes valid in wdata; bit i set means lane i was written.
vec_count  output  $clog2(DEPTH)+1  vectors currently buffered.

Behaviour:
- Reset (async assert, sync release) clears the following:
  - lane index to 0;
  - assembly data and mask to 0;
  - FIFO pointers and count to 0.
- Outputs after reset: s_ready=1, we=0, wdata=0, wmask=0, vec_count=0.
- Beat accept = s_valid && s_ready. s_ready = (vec_count < DEPTH), combinational from registered count.
- On an accepted beat:
  - s_data is written into assembly lane idx, and mask bit idx is set.
  - If idx == WIDTH_VECTOR-1 or s_last=1, the vector closes: the assembled vector (including this beat) and its mask are pushed into the FIFO on the same edge, then idx, assembly data and mask clear to 0.
  - Otherwise idx increments by 1.
- Unwritten lanes of an early-closed vector read as 0, with the matching wmask bits at 0.
- s_last on the first beat of a vector produces a vector with wmask = 1.
- No push occurs without an accepted beat; s_last without s_valid is ignored.
- Output side:
  - we = (vec_count != 0) && m_ready, combinational.
  - wdata and wmask show the FIFO head while non-empty, and 0 while empty.
  - The head pops on every cycle we=1.
- Latency: a vector closed on edge k is visible at wdata/wmask, with we possible, in cycle k+1. Minimum latency is 1 cycle from the final accepted beat.
- Simultaneous push and pop: count is unchanged and both pointers advance. This can only happen when count < DEPTH, because s_ready gates the push.
- Full FIFO:
  - s_ready=0, and the partial assembly register holds its contents.
  - A pop frees a slot; s_ready rises in the next cycle.
  - No push or pop is ever lost or duplicated.
- Pointers wrap modulo DEPTH. vec_count stays within 0..DEPTH.
- m_ready=0 holds we=0 and the head stable.
- Reset mid-vector discards the partial assembly and all buffered vectors. No we pulse occurs after reset until a new vector closes.
- Throughput: steady state is one scalar word per cycle, with one vector out per WIDTH_VECTOR cycles.

Test Plan:
- Full vectors: reset, m_ready=1, stream words 1..16 (WIDTH_VECTOR=8) back-to-back.
  - we pulses in the cycle after word 8 with wdata lanes 0..7 = 1..8 and wmask=8'hFF.
  - A second pulse follows after word 16 with lanes = 9..16.
- Early close: send 10, 20, 30 with s_last on 30.
  - One we pulse with lanes 0..2 = 10/20/30, lanes 3..7 = 0, wmask=8'h07.
  - The next vector starts at lane 0.
- Backpressure: hold m_ready=0 and stream 24 words (DEPTH=2).
  - s_ready drops after the 16th word; vec_count=2.
  - Words 17..24 wait with no loss.
  - Raising m_ready gives three vectors in order 1..8, 9..16, 17..24, the first two on consecutive cycles.
- Simultaneous push and pop: with vec_count=1 and m_ready=1, close a vector on the same edge the head pops.
  - vec_count stays 1 and data order is preserved.
- Reset mid-operation: 5 words assembled and 1 vector buffered, then pulse rstn low for 1 cycle.
  - vec_count=0, we=0, s_ready=1.
  - The next 8 words produce a single vector containing only those words.

Source files
------------

// File: rtl/vector_loader.sv
// Packs a scalar word stream into WIDTH_VECTOR-lane vectors for the core's load port.
// Closed vectors queue in a small FIFO and drain one per cycle under m_ready.
module vector_loader #(
  parameter int WIDTH_VECTOR = 8,
  parameter int N            = 32,
  parameter int DEPTH        = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [N-1:0]                   s_data,
  input  logic                           s_last,
  input  logic                           m_ready,
  output logic                           we,
  output logic [WIDTH_VECTOR-1:0][N-1:0] wdata,
  output logic [WIDTH_VECTOR-1:0]        wmask,
  output logic [$clog2(DEPTH):0]         vec_count
);

  localparam int IW = (WIDTH_VECTOR > 1) ? $clog2(WIDTH_VECTOR) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [WIDTH_VECTOR-1:0][N-1:0] vec_t;
  typedef logic [WIDTH_VECTOR-1:0]        msk_t;

  logic [IW-1:0] idx_q, idx_d;
  vec_t          asm_q, asm_d;
  msk_t          amsk_q, amsk_d;
  vec_t          dmem_q [DEPTH];
  vec_t          dmem_d [DEPTH];
  msk_t          mmem_q [DEPTH];
  msk_t          mmem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic accept;
  logic close;
  logic pop;
  logic nempty;
  vec_t vec;
  msk_t msk;

  assign nempty    = (cnt_q != '0);
  assign s_ready   = (cnt_q < CW'(DEPTH));
  assign accept    = s_valid && s_ready;
  assign close     = accept &&
                     (s_last || (idx_q == IW'(WIDTH_VECTOR - 1)));
  assign we        = nempty && m_ready;
  assign pop       = we;
  assign wdata     = nempty ? dmem_q[rptr_q] : '0;
  assign wmask     = nempty ? mmem_q[rptr_q] : '0;
  assign vec_count = cnt_q;

  always_comb begin
    vec         = asm_q;
    msk         = amsk_q;
    vec[idx_q]  = s_data;
    msk[idx_q]  = 1'b1;
    idx_d       = idx_q;
    asm_d       = asm_q;
    amsk_d      = amsk_q;
    dmem_d      = dmem_q;
    mmem_d      = mmem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    if (close) begin
      // the closing beat goes straight into the FIFO
      dmem_d[wptr_q] = vec;
      mmem_d[wptr_q] = msk;
      wptr_d         = wptr_q + PW'(1);
      idx_d          = '0;
      asm_d          = '0;
      amsk_d         = '0;
    end else if (accept) begin
      idx_d  = idx_q + IW'(1);
      asm_d  = vec;
      amsk_d = msk;
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    unique case ({close, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q  <= '0;
      asm_q  <= '0;
      amsk_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dmem_q[i] <= '0;
        mmem_q[i] <= '0;
      end
    end else begin
      idx_q  <= idx_d;
      asm_q  <= asm_d;
      amsk_q <= amsk_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        dmem_q[i] <= dmem_d[i];
        mmem_q[i] <= mmem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_vector_loader.sv
// Scoreboard bench for vector_loader: word-list model feeds an expected-vector
// queue, a negedge monitor pops and compares whenever the core side fires.
module tb_vector_loader;

  localparam int W  = 8;
  localparam int N  = 32;
  localparam int D  = 2;
  localparam int CW = $clog2(D) + 1;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                s_valid = 1'b0;
  logic                s_last = 1'b0;
  logic                m_ready = 1'b0;
  logic [N-1:0]        s_data = '0;
  logic                s_ready;
  logic                we;
  logic [W-1:0][N-1:0] wdata;
  logic [W-1:0]        wmask;
  logic [CW-1:0]       vec_count;

  typedef struct packed {
    logic [W-1:0][N-1:0] d;
    logic [W-1:0]        m;
  } vec_t;

  vec_t         exp_q[$];
  vec_t         pend;
  vec_t         tmp;
  vec_t         got;
  bit           pend_v = 0;
  logic [N-1:0] part[$];
  int           tests = 0;
  int           fails = 0;

  vector_loader #(.WIDTH_VECTOR(W), .N(N), .DEPTH(D)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .m_ready(m_ready), .we(we),
    .wdata(wdata), .wmask(wmask),
    .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a vector is just the list of words accepted since the last close.
  always @(negedge clk) begin
    if (rstn && s_valid && s_ready) begin
      part.push_back(s_data);
      if (part.size() == W || s_last) begin
        tmp = '0;
        foreach (part[i]) begin
          tmp.d[i] = part[i];
          tmp.m[i] = 1'b1;
        end
        pend   = tmp;
        pend_v = 1;
        part.delete();
      end
    end
  end

  always @(posedge clk) begin
    if (pend_v) begin
      exp_q.push_back(pend);
      pend_v = 0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rstn) begin
      chk("vec_count", 256'(vec_count), 256'(exp_q.size()));
      chk("s_ready", 256'(s_ready), 256'(exp_q.size() < D));
      chk("we", 256'(we), 256'(exp_q.size() != 0 && m_ready));
      if (exp_q.size() == 0) begin
        chk("wdata_empty", 256'(wdata), 256'(0));
        chk("wmask_empty", 256'(wmask), 256'(0));
      end else if (we) begin
        got = exp_q.pop_front();
        chk("wdata", 256'(wdata), 256'(got.d));
        chk("wmask", 256'(wmask), 256'(got.m));
      end
    end
  end

  task automatic send(input logic [N-1:0] d, input bit last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got s_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain(input string nm);
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk(nm, 256'(vec_count), 256'(0));
    chk({nm, "_model"}, 256'(exp_q.size()), 256'(0));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 256'(s_ready), 256'(1));
    chk("rst_we", 256'(we), 256'(0));
    chk("rst_wdata", 256'(wdata), 256'(0));
    chk("rst_wmask", 256'(wmask), 256'(0));
    chk("rst_count", 256'(vec_count), 256'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // full vectors back-to-back
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) send(N'(i), 1'b0);
    drain("full_drain");

    // early close, then a fresh vector from lane 0
    send(N'(10), 1'b0);
    send(N'(20), 1'b0);
    send(N'(30), 1'b1);
    send(N'(40), 1'b0);
    send(N'(50), 1'b1);
    send(N'(60), 1'b1);
    drain("early_drain");

    // backpressure: 24 words against a 2-deep FIFO
    m_ready = 1'b0;
    fork
      for (int i = 1; i <= 24; i++) send(N'(i), 1'b0);
      begin
        repeat (22) @(negedge clk);
        chk("bp_count", 256'(vec_count), 256'(2));
        chk("bp_s_ready", 256'(s_ready), 256'(0));
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // push and pop on the same edge
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(N'(100 + i), 1'b0);
    for (int i = 0; i < 7; i++) send(N'(200 + i), 1'b0);
    m_ready = 1'b1;
    send(N'(207), 1'b0);
    @(negedge clk);
    chk("pp_count", 256'(vec_count), 256'(1));
    drain("pp_drain");

    // reset mid-vector with one buffered vector
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(N'(300 + i), 1'b0);
    for (int i = 0; i < 5; i++) send(N'(400 + i), 1'b0);
    rstn = 1'b0;
    exp_q.delete();
    part.delete();
    pend_v = 0;
    @(negedge clk);
    chk("mid_rst_count", 256'(vec_count), 256'(0));
    chk("mid_rst_we", 256'(we), 256'(0));
    chk("mid_rst_s_ready", 256'(s_ready), 256'(1));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(N'(500 + i), 1'b0);
    drain("rst_drain");

    // randomized traffic
    repeat (400) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = $urandom;
      s_last  = ($urandom_range(0, 5) == 0);
      m_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
